// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone B4 pipelined initiator copying a block of words in read-then-write chunks
module wb_dma_copy #(
  parameter int BURST_WORDS = 8,
  parameter int LEN_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len_words,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [3:0]       o_wb_sel,
  output logic [31:0]      o_wb_addr,
  output logic [31:0]      o_wb_data,
  input  logic [31:0]      i_wb_data,
  input  logic             i_wb_ack,
  input  logic             i_wb_stall,
  input  logic             i_wb_err
);
  localparam int AW = $clog2(BURST_WORDS);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, READ, GAP, WRITE, DONE, ABORT} state_t;
  state_t state, state_n;
  logic [31:0] src, dst;
  logic [LEN_W-1:0] rem, rem_left;
  logic [CW-1:0] chunk, issued, acked;
  logic wr_phase, err_q, active, accept, ack_ok, phase_done;
  logic [31:0] buffer [BURST_WORDS];
  function automatic logic [CW-1:0] chunk_of(input logic [LEN_W-1:0] n);
    return (n >= LEN_W'(BURST_WORDS)) ? CW'(BURST_WORDS) : CW'(n);
  endfunction
  assign active     = state == READ || state == WRITE;
  assign o_wb_cyc   = active;
  assign o_wb_stb   = active && issued < chunk;
  assign o_wb_we    = state == WRITE;
  assign o_wb_sel   = 4'hF;
  assign o_wb_addr  = active ? (o_wb_we ? dst : src) + (32'(issued) << 2) : '0;
  assign o_wb_data  = o_wb_we ? buffer[issued[AW-1:0]] : '0;
  assign o_busy     = active || state == GAP;
  assign o_done     = state == DONE || state == ABORT;
  assign o_error    = err_q;
  assign accept     = o_wb_stb && !i_wb_stall;
  assign ack_ok     = active && i_wb_ack && acked < chunk;
  assign phase_done = ack_ok && acked == chunk - CW'(1);
  assign rem_left   = rem - LEN_W'(chunk);
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  // next-state: a bus error in any active phase wins over completion
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = i_start ? (i_len_words == '0 ? DONE : READ) : IDLE;
      READ:    state_n = i_wb_err ? ABORT : phase_done ? GAP : READ;
      GAP:     state_n = wr_phase ? WRITE : READ;
      WRITE:   state_n = i_wb_err ? ABORT : phase_done ? (rem_left == '0 ? DONE : GAP) : WRITE;
      default: state_n = IDLE;
    endcase
  end
  // transfer bookkeeping: latch request, count accepts/acks, advance pointers after each write chunk
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      src      <= '0;
      dst      <= '0;
      rem      <= '0;
      chunk    <= '0;
      issued   <= '0;
      acked    <= '0;
      wr_phase <= 1'b0;
      err_q    <= 1'b0;
    end else if (state == IDLE && i_start) begin
      src      <= i_src_addr & ~32'd3;
      dst      <= i_dst_addr & ~32'd3;
      rem      <= i_len_words;
      chunk    <= chunk_of(i_len_words);
      issued   <= '0;
      acked    <= '0;
      wr_phase <= 1'b0;
      err_q    <= 1'b0;
    end else if (active && i_wb_err) begin
      err_q <= 1'b1;
    end else if (phase_done) begin
      issued   <= '0;
      acked    <= '0;
      wr_phase <= !wr_phase;
      if (state == WRITE) begin
        src   <= src + (32'(chunk) << 2);
        dst   <= dst + (32'(chunk) << 2);
        rem   <= rem_left;
        chunk <= chunk_of(rem_left);
      end
    end else if (active) begin
      issued <= issued + CW'(accept);
      acked  <= acked + CW'(ack_ok);
    end
  // chunk buffer filled in ack order during the read phase
  always_ff @(posedge i_clk)
    if (state == READ && ack_ok) buffer[acked[AW-1:0]] <= i_wb_data;
endmodule
